m_btb_lru: RTL and testbench

- Parametrised successor to the 4-slot branch predictor. It is a fully-associative branch target buffer with ENTRIES slots and true-LRU replacement.
- Each slot holds a valid bit, a branch PC tag, a target, and a CTR_W-bit saturating direction counter.
- The IF stage looks up the current PC combinationally. The EX stage updates the buffer with each resolved BEQ/BNE.
- New versus the previous generation: explicit valid bits (no sentinel address), parametrised depth and width, a flush input, target refresh on taken hits, and optional statistics counters.

---
 rtl/m_btb_lru_pkg.sv | 26 ++
 rtl/m_btb_lru_if.sv | 34 +++
 rtl/m_btb_lru_sat_ctr.sv | 17 +
 rtl/m_btb_lru.sv | 124 ++++++++++++
 tb/tb_m_btb_lru.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/m_btb_lru_pkg.sv
// Shared helpers for the LRU branch target buffer: log2 sizing, default
// geometry and the counter values that newly allocated entries start from.
package bp_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int BTB_ADDR_W  = 11;
  localparam int BTB_ENTRIES = 4;
  localparam int BTB_CTR_W   = 2;
  localparam int BTB_AGE_W   = clog2(BTB_ENTRIES);

  // New entries start one step either side of the taken/not-taken threshold.
  function automatic int weak_taken(input int ctr_w);
    return 1 << (ctr_w - 1);
  endfunction

  function automatic int weak_not_taken(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/m_btb_lru_if.sv
// EX-update / IF-lookup bus of the branch target buffer.
// Statistics signals exist only when BTB_STATS_EN is defined.
interface m_btb_lru_if #(parameter int ADDR_W = 11);
  logic              w_flush;
  logic              w_upd_en;
  logic [ADDR_W-1:0] w_upd_pc;
  logic              w_upd_taken;
  logic [ADDR_W-1:0] w_upd_dst;
  logic [ADDR_W-1:0] w_lkp_pc;
  logic              w_lkp_hit;
  logic              w_lkp_taken;
  logic [ADDR_W-1:0] w_lkp_dst;
`ifdef BTB_STATS_EN
  logic [31:0]       w_upd_cnt;
  logic [31:0]       w_miss_cnt;
  logic [31:0]       w_mispred_cnt;
`endif

  modport master (
    output w_flush, w_upd_en, w_upd_pc, w_upd_taken, w_upd_dst, w_lkp_pc,
`ifdef BTB_STATS_EN
    input  w_upd_cnt, w_miss_cnt, w_mispred_cnt,
`endif
    input  w_lkp_hit, w_lkp_taken, w_lkp_dst
  );

  modport slave (
    input  w_flush, w_upd_en, w_upd_pc, w_upd_taken, w_upd_dst, w_lkp_pc,
`ifdef BTB_STATS_EN
    output w_upd_cnt, w_miss_cnt, w_mispred_cnt,
`endif
    output w_lkp_hit, w_lkp_taken, w_lkp_dst
  );
endinterface

// File: rtl/m_btb_lru_sat_ctr.sv
// Saturating up/down next-value logic for one direction counter.
module m_sat_ctr #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             inc,
  output logic [CTR_W-1:0] nxt
);
  always_comb begin
    nxt = ctr;
    if (inc) begin
      if (ctr != '1) nxt = ctr + 1'b1;
    end else begin
      if (ctr != '0) nxt = ctr - 1'b1;
    end
  end
endmodule

// File: rtl/m_btb_lru.sv
// Fully-associative branch target buffer with true-LRU replacement.
// Define BTB_STATS_EN to add saturating update/miss/mispredict counters.
module m_btb_lru
  import bp_pkg::*;
#(
  parameter int ADDR_W  = BTB_ADDR_W,
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int CTR_W   = BTB_CTR_W
) (
  input logic    w_clk,
  input logic    w_rst,
  m_btb_lru_if.slave bus
);
  localparam int AGE_W = clog2(ENTRIES);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(ENTRIES - 1);
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(weak_taken(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(weak_not_taken(CTR_W));

  logic [ENTRIES-1:0] valid;
  logic [ADDR_W-1:0]  tag     [ENTRIES];
  logic [ADDR_W-1:0]  dst     [ENTRIES];
  logic [CTR_W-1:0]   ctr     [ENTRIES];
  logic [CTR_W-1:0]   ctr_nxt [ENTRIES];
  logic [AGE_W-1:0]   age     [ENTRIES];

  logic             lkp_hit, upd_hit, has_free, upd_go;
  logic [AGE_W-1:0] lkp_idx, upd_idx, free_idx, lru_idx, sel, sel_age;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    m_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
      .ctr (ctr[g]),
      .inc (bus.w_upd_taken),
      .nxt (ctr_nxt[g])
    );
  end

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    lkp_hit  = 1'b0;
    lkp_idx  = '0;
    upd_hit  = 1'b0;
    upd_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    lru_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && tag[i] == bus.w_lkp_pc) begin
        lkp_hit = 1'b1;
        lkp_idx = AGE_W'(i);
      end
      if (valid[i] && tag[i] == bus.w_upd_pc) begin
        upd_hit = 1'b1;
        upd_idx = AGE_W'(i);
      end
      if (!valid[i]) begin
        has_free = 1'b1;
        free_idx = AGE_W'(i);
      end
      if (age[i] == AGE_MAX) lru_idx = AGE_W'(i);
    end
  end

  assign sel     = upd_hit ? upd_idx : (has_free ? free_idx : lru_idx);
  assign sel_age = age[sel];
  assign upd_go  = bus.w_upd_en && !bus.w_flush;

  assign bus.w_lkp_hit   = lkp_hit;
  assign bus.w_lkp_taken = lkp_hit && ctr[lkp_idx][CTR_W-1];
  assign bus.w_lkp_dst   = lkp_hit ? dst[lkp_idx] : '0;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i] <= '0;
        dst[i] <= '0;
        ctr[i] <= '0;
        age[i] <= AGE_W'(i);
      end
    end else if (bus.w_flush) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) age[i] <= AGE_W'(i);
    end else if (upd_go) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (AGE_W'(i) == sel)      age[i] <= '0;
        else if (age[i] < sel_age) age[i] <= age[i] + 1'b1;
      end
      if (upd_hit) begin
        ctr[sel] <= ctr_nxt[sel];
        if (bus.w_upd_taken) dst[sel] <= bus.w_upd_dst;
      end else begin
        valid[sel] <= 1'b1;
        tag[sel]   <= bus.w_upd_pc;
        dst[sel]   <= bus.w_upd_dst;
        ctr[sel]   <= bus.w_upd_taken ? CTR_WT : CTR_WNT;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] upd_cnt, miss_cnt, mispred_cnt;
  logic        pred_dir;

  assign pred_dir = upd_hit && ctr[upd_idx][CTR_W-1];

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      upd_cnt     <= '0;
      miss_cnt    <= '0;
      mispred_cnt <= '0;
    end else if (upd_go) begin
      if (upd_cnt != '1) upd_cnt <= upd_cnt + 1'b1;
      if (!upd_hit && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      if (pred_dir != bus.w_upd_taken && mispred_cnt != '1)
        mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

  assign bus.w_upd_cnt     = upd_cnt;
  assign bus.w_miss_cnt    = miss_cnt;
  assign bus.w_mispred_cnt = mispred_cnt;
`endif
endmodule

// File: tb/tb_m_btb_lru.sv
// Directed bench for m_btb_lru (4 entries, 2-bit counters); covers the
// BTB_STATS_EN counters when that macro is defined.
module tb_m_btb_lru;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  m_btb_lru_if #(.ADDR_W(11)) bif ();

  m_btb_lru #(.ADDR_W(11), .ENTRIES(4), .CTR_W(2)) dut (
    .w_clk (clk),
    .w_rst (rst),
    .bus   (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_perm();
    logic [3:0] seen;
    seen = '0;
    for (int i = 0; i < 4; i++) seen[dut.age[i]] = 1'b1;
    chk("age_perm", {28'd0, seen}, 32'hf);
  endtask

  task automatic chk_ages(input int a0, input int a1, input int a2, input int a3);
    chk("age0", {30'd0, dut.age[0]}, a0);
    chk("age1", {30'd0, dut.age[1]}, a1);
    chk("age2", {30'd0, dut.age[2]}, a2);
    chk("age3", {30'd0, dut.age[3]}, a3);
  endtask

  task automatic look(input string tag, input logic [10:0] pc, input logic hit,
                      input logic tk, input logic [10:0] d);
    bif.w_lkp_pc = pc;
    #1;
    chk({tag, "_hit"}, {31'd0, bif.w_lkp_hit}, {31'd0, hit});
    chk({tag, "_taken"}, {31'd0, bif.w_lkp_taken}, {31'd0, tk});
    chk({tag, "_dst"}, {21'd0, bif.w_lkp_dst}, {21'd0, d});
  endtask

  task automatic upd(input logic [10:0] pc, input logic tk, input logic [10:0] d);
    @(negedge clk);
    bif.w_upd_en    = 1'b1;
    bif.w_upd_pc    = pc;
    bif.w_upd_taken = tk;
    bif.w_upd_dst   = d;
    @(posedge clk);
    #1;
    bif.w_upd_en = 1'b0;
    chk_perm();
  endtask

  initial begin
    rst             = 1'b1;
    bif.w_flush     = 1'b0;
    bif.w_upd_en    = 1'b0;
    bif.w_upd_pc    = '0;
    bif.w_upd_taken = 1'b0;
    bif.w_upd_dst   = '0;
    bif.w_lkp_pc    = 11'h010;

    look("rst", 11'h010, 0, 0, 11'h000);
    chk_ages(0, 1, 2, 3);
    @(negedge clk);
    rst = 1'b0;

    // Counter walk on a single entry
    upd(11'h010, 1, 11'h020);
    look("alloc", 11'h010, 1, 1, 11'h020);
    chk("ctr_alloc", {30'd0, dut.ctr[0]}, 2);
    upd(11'h010, 0, 11'h099);
    look("nt1", 11'h010, 1, 0, 11'h020);
    chk("ctr_nt1", {30'd0, dut.ctr[0]}, 1);
    upd(11'h010, 0, 11'h099);
    chk("ctr_nt2", {30'd0, dut.ctr[0]}, 0);
    upd(11'h010, 0, 11'h099);
    look("nt3", 11'h010, 1, 0, 11'h020);
    chk("ctr_sat0", {30'd0, dut.ctr[0]}, 0);

    // Plain flush, then fill and evict the LRU slot
    @(negedge clk);
    bif.w_flush = 1'b1;
    @(posedge clk);
    #1;
    bif.w_flush = 1'b0;
    look("flush0", 11'h010, 0, 0, 11'h000);

    upd(11'h010, 1, 11'h110);
    upd(11'h020, 1, 11'h120);
    upd(11'h030, 1, 11'h130);
    upd(11'h040, 1, 11'h140);
    chk_ages(3, 2, 1, 0);
    upd(11'h010, 1, 11'h110);
    chk_ages(0, 3, 2, 1);
    upd(11'h050, 0, 11'h150);
    chk_ages(1, 0, 3, 2);
    look("ev10", 11'h010, 1, 1, 11'h110);
    look("ev20", 11'h020, 0, 0, 11'h000);
    look("ev30", 11'h030, 1, 1, 11'h130);
    look("ev40", 11'h040, 1, 1, 11'h140);
    look("ev50", 11'h050, 1, 0, 11'h150);

    // Target refresh only on taken hits
    upd(11'h010, 1, 11'h0A0);
    look("refr_t", 11'h010, 1, 1, 11'h0A0);
    chk("ctr_sat3", {30'd0, dut.ctr[0]}, 3);
    upd(11'h010, 0, 11'h0B0);
    look("refr_nt", 11'h010, 1, 1, 11'h0A0);

    // Flush wins over a same-cycle update
    @(negedge clk);
    bif.w_flush     = 1'b1;
    bif.w_upd_en    = 1'b1;
    bif.w_upd_pc    = 11'h060;
    bif.w_upd_taken = 1'b1;
    bif.w_upd_dst   = 11'h160;
    @(posedge clk);
    #1;
    bif.w_flush  = 1'b0;
    bif.w_upd_en = 1'b0;
    look("fl60", 11'h060, 0, 0, 11'h000);
    look("fl10", 11'h010, 0, 0, 11'h000);
    look("fl30", 11'h030, 0, 0, 11'h000);
    chk_ages(0, 1, 2, 3);

    // Lookup during an allocating update sees pre-edge state
    @(negedge clk);
    bif.w_upd_en    = 1'b1;
    bif.w_upd_pc    = 11'h070;
    bif.w_upd_taken = 1'b1;
    bif.w_upd_dst   = 11'h170;
    look("same_pre", 11'h070, 0, 0, 11'h000);
    @(posedge clk);
    #1;
    bif.w_upd_en = 1'b0;
    look("same_post", 11'h070, 1, 1, 11'h170);

    // Async reset with three valid slots
    upd(11'h080, 1, 11'h180);
    upd(11'h090, 0, 11'h190);
    look("pre_rst", 11'h080, 1, 1, 11'h180);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_hit", {31'd0, bif.w_lkp_hit}, 0);
    chk("arst_taken", {31'd0, bif.w_lkp_taken}, 0);
    chk("arst_dst", {21'd0, bif.w_lkp_dst}, 0);
    @(negedge clk);
    rst = 1'b0;
    look("post_rst", 11'h070, 0, 0, 11'h000);

`ifdef BTB_STATS_EN
    upd(11'h200, 1, 11'h300);
    upd(11'h200, 1, 11'h300);
    upd(11'h200, 0, 11'h300);
    chk("st_upd", bif.w_upd_cnt, 3);
    chk("st_miss", bif.w_miss_cnt, 1);
    chk("st_mispred", bif.w_mispred_cnt, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
